// File: rtl/etc_de2_pkg.sv
// Shared definitions for the DE2 status block: count-mode encodings, key roles
// and the seven-segment glyph decoder.
package etc_de2_pkg;

   typedef enum logic [1:0] {
      MODE_KEY  = 2'd0,
      MODE_GPIO = 2'd1,
      MODE_TICK = 2'd2,
      MODE_SW   = 2'd3
   } mode_e;

   localparam int KEY_COUNT   = 0;
   localparam int KEY_CLEAR   = 1;
   localparam int KEY_HOLD    = 2;
   localparam int KEY_ACT_CLR = 3;

   // Active-low glyphs, bit 6 = segment g, bit 0 = segment a.
   function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/etc_status_de2_key_debounce.sv
// One push-button: two-flop synchroniser, stability counter and a single-cycle
// pulse when a press (not a release) is accepted.
module key_debounce
   import etc_de2_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_level,
   output logic o_pulse
);

   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_pulse;
   logic [CW-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_pulse  <= 1'b0;
         r_count  <= '0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         if (r_sync2 == r_stable) begin
            r_count <= '0;
         end else if (r_count == LAST) begin
            r_stable <= r_sync2;
            r_count  <= '0;
            // Only a 1->0 transition of the active-low level is a press.
            r_pulse  <= r_stable;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_level = ~r_stable;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/etc_status_de2.sv
// DE2 housekeeping: debounced keys, mode-selected event counter on HEX digits,
// sticky GPIO activity flag and a resettable VGA clock divider with pixel enable.
module etc_status_de2
   import etc_de2_pkg::*;
#(
   parameter int NUM_KEYS     = 4,
   parameter int NUM_DIGITS   = 8,
   parameter int GPIO_W       = 36,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int TICK_CYC     = 50000000,
   parameter int CLK_DIV      = 2
) (
   input  logic                      i_clk50m,
   input  logic                      i_rst,
   input  logic [NUM_KEYS-1:0]       i_key_n,
   input  logic [GPIO_W-1:0]         i_gpio_in,
   input  logic [4*NUM_DIGITS-1:0]   i_sw_in,
   input  logic [1:0]                i_mode,
   output logic [NUM_KEYS-1:0]       o_key_level,
   output logic [NUM_KEYS-1:0]       o_key_pulse,
   output logic [4*NUM_DIGITS-1:0]   o_event_cnt,
   output logic [7*NUM_DIGITS-1:0]   o_hex_out,
   output logic                      o_gpio_act,
   output logic                      o_vga_clk,
   output logic                      o_pix_en
);

   localparam int CNT_W = 4 * NUM_DIGITS;
   localparam int TW    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);
   localparam int HALF  = CLK_DIV / 2;
   localparam int VW    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [VW-1:0] VGA_LAST = VW'(HALF - 1);

   logic [NUM_KEYS-1:0]    w_key_pulse;
   logic [GPIO_W-1:0]      r_gpio_sync1;
   logic [GPIO_W-1:0]      r_gpio_sync2;
   logic                   r_gpio_any_d;
   logic                   w_gpio_any;
   logic                   w_gpio_rise;
   logic [TW-1:0]          r_presc;
   logic                   w_tick;
   logic                   w_inc;
   logic [CNT_W-1:0]       r_event_cnt;
   logic                   r_hold;
   logic                   r_gpio_act;
   logic [CNT_W-1:0]       w_disp;
   logic [7*NUM_DIGITS-1:0] w_hex_next;
   logic [7*NUM_DIGITS-1:0] r_hex;
   logic [VW-1:0]          r_vga_cnt;
   logic                   r_vga_clk;
   logic                   r_pix_en;
   logic                   w_vga_term;

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
         .i_clk   (i_clk50m),
         .i_rst   (i_rst),
         .i_key_n (i_key_n[gi]),
         .o_level (o_key_level[gi]),
         .o_pulse (w_key_pulse[gi])
      );
   end

   assign w_gpio_any  = |r_gpio_sync2;
   assign w_gpio_rise = w_gpio_any & ~r_gpio_any_d;
   assign w_tick      = (r_presc == TICK_LAST);

   always_comb begin
      w_inc = 1'b0;
      case (mode_e'(i_mode))
         MODE_KEY:  w_inc = w_key_pulse[KEY_COUNT];
         MODE_GPIO: w_inc = w_gpio_rise;
         MODE_TICK: w_inc = w_tick;
         default:   w_inc = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk50m) begin
      if (i_rst) begin
         r_gpio_sync1 <= '0;
         r_gpio_sync2 <= '0;
         r_gpio_any_d <= 1'b0;
         r_presc      <= '0;
         r_event_cnt  <= '0;
         r_hold       <= 1'b0;
         r_gpio_act   <= 1'b0;
      end else begin
         r_gpio_sync1 <= i_gpio_in;
         r_gpio_sync2 <= r_gpio_sync1;
         r_gpio_any_d <= w_gpio_any;
         r_presc      <= w_tick ? '0 : r_presc + 1'b1;
         if (w_key_pulse[KEY_CLEAR]) begin
            r_event_cnt <= '0;
         end else if (w_inc && !r_hold) begin
            r_event_cnt <= r_event_cnt + 1'b1;
         end
         if (w_key_pulse[KEY_HOLD]) begin
            r_hold <= ~r_hold;
         end
         // A new rise beats a simultaneous clear so no activity is lost.
         if (w_gpio_rise) begin
            r_gpio_act <= 1'b1;
         end else if (w_key_pulse[KEY_ACT_CLR]) begin
            r_gpio_act <= 1'b0;
         end
      end
   end

   assign w_disp = (i_mode == MODE_SW) ? i_sw_in : r_event_cnt;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_hex_next[7*gi +: 7] = seg7_decode(w_disp[4*gi +: 4]);
   end

   always_ff @(posedge i_clk50m) begin
      if (i_rst) begin
         r_hex <= {NUM_DIGITS{7'b1000000}};
      end else begin
         r_hex <= w_hex_next;
      end
   end

   assign w_vga_term = (r_vga_cnt == VGA_LAST);

   always_ff @(posedge i_clk50m) begin
      if (i_rst) begin
         r_vga_cnt <= '0;
         r_vga_clk <= 1'b0;
         r_pix_en  <= 1'b0;
      end else begin
         r_pix_en <= 1'b0;
         if (w_vga_term) begin
            r_vga_cnt <= '0;
            r_vga_clk <= ~r_vga_clk;
            r_pix_en  <= ~r_vga_clk;
         end else begin
            r_vga_cnt <= r_vga_cnt + 1'b1;
         end
      end
   end

   assign o_key_pulse = w_key_pulse;
   assign o_event_cnt = r_event_cnt;
   assign o_hex_out   = r_hex;
   assign o_gpio_act  = r_gpio_act;
   assign o_vga_clk   = r_vga_clk;
   assign o_pix_en    = r_pix_en;

endmodule

// File: tb/tb_etc_status_de2.sv
// Bench for etc_status_de2: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a window/arithmetic model.
module tb_etc_status_de2;

   localparam int NK   = 4;
   localparam int ND   = 2;
   localparam int GW   = 36;
   localparam int DEB  = 4;
   localparam int TICK = 10;
   localparam int CDIV = 4;
   localparam int HALF = CDIV / 2;
   localparam int CW   = 4 * ND;

   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [NK-1:0]     key_n;
   logic [GW-1:0]     gpio;
   logic [CW-1:0]     sw;
   logic [1:0]        mode;
   logic [NK-1:0]     key_level;
   logic [NK-1:0]     key_pulse;
   logic [CW-1:0]     event_cnt;
   logic [7*ND-1:0]   hex_out;
   logic              gpio_act;
   logic              vga_clk;
   logic              pix_en;

   etc_status_de2 #(
      .NUM_KEYS(NK), .NUM_DIGITS(ND), .GPIO_W(GW),
      .DEBOUNCE_CYC(DEB), .TICK_CYC(TICK), .CLK_DIV(CDIV)
   ) dut (
      .i_clk50m    (clk),
      .i_rst       (rst),
      .i_key_n     (key_n),
      .i_gpio_in   (gpio),
      .i_sw_in     (sw),
      .i_mode      (mode),
      .o_key_level (key_level),
      .o_key_pulse (key_pulse),
      .o_event_cnt (event_cnt),
      .o_hex_out   (hex_out),
      .o_gpio_act  (gpio_act),
      .o_vga_clk   (vga_clk),
      .o_pix_en    (pix_en)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a key is accepted once its synchronised value has differed from the
   // accepted state for DEB consecutive samples; time-based outputs are pure
   // arithmetic on the number of edges since reset.
   logic [NK-1:0]    m_p1, m_p2, m_stable, m_pulse, m_level;
   logic [DEB-1:0]   m_win [NK];
   logic [2:0]       m_gsh;
   int unsigned      m_cnt;
   logic             m_hold, m_act, m_vga, m_pix;
   int               m_ncyc;
   logic [7*ND-1:0]  m_hex;
   logic [CW-1:0]    m_cnt_v;

   task automatic model_step();
      logic          rise, tick, inc;
      logic [CW-1:0] disp;
      logic [NK-1:0] synced;
      if (rst) begin
         m_p1 = '1; m_p2 = '1; m_stable = '1; m_pulse = '0;
         for (int k = 0; k < NK; k++) m_win[k] = '1;
         m_gsh = '0; m_cnt = 0; m_hold = 1'b0; m_act = 1'b0; m_ncyc = 0;
         m_hex = {ND{7'b1000000}};
      end else begin
         rise = m_gsh[1] & ~m_gsh[2];
         tick = ((m_ncyc + 1) % TICK) == 0;
         case (mode)
            2'd0:    inc = m_pulse[0];
            2'd1:    inc = rise;
            2'd2:    inc = tick;
            default: inc = 1'b0;
         endcase
         disp = (mode == 2'd3) ? sw : CW'(m_cnt);
         for (int d = 0; d < ND; d++) m_hex[7*d +: 7] = GLYPH[disp[4*d +: 4]];
         if (m_pulse[1]) m_cnt = 0;
         else if (inc && !m_hold) m_cnt = (m_cnt + 1) % (1 << CW);
         if (m_pulse[2]) m_hold = ~m_hold;
         if (rise) m_act = 1'b1;
         else if (m_pulse[3]) m_act = 1'b0;
         synced = m_p2;
         for (int k = 0; k < NK; k++) begin
            m_win[k] = {m_win[k][DEB-2:0], synced[k]};
            m_pulse[k] = 1'b0;
            if (m_win[k] == {DEB{~m_stable[k]}}) begin
               m_pulse[k]  = m_stable[k];
               m_stable[k] = ~m_stable[k];
            end
         end
         m_p2 = m_p1;
         m_p1 = key_n;
         m_gsh = {m_gsh[1:0], |gpio};
         m_ncyc++;
      end
      m_level = ~m_stable;
      m_vga   = ((m_ncyc / HALF) % 2) == 1;
      m_pix   = m_vga && ((m_ncyc % HALF) == 0);
      m_cnt_v = CW'(m_cnt);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         check("key_level", key_level, m_level);
         check("key_pulse", key_pulse, m_pulse);
         check("event_cnt", event_cnt, m_cnt_v);
         check("hex_out",   hex_out,   m_hex);
         check("gpio_act",  gpio_act,  m_act);
         check("vga_clk",   vga_clk,   m_vga);
         check("pix_en",    pix_en,    m_pix);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(3);
      rst = 1'b0;
   endtask

   int           npulse, npix;
   int           dur [NK];
   logic [15:0]  vga_pat, pix_pat;

   initial begin
      rst = 1'b1; key_n = '1; gpio = '0; sw = '0; mode = 2'd0;
      do_reset();
      check("rst_level", key_level, 4'h0);
      check("rst_pulse", key_pulse, 4'h0);
      check("rst_cnt",   event_cnt, 8'h00);
      check("rst_hex",   hex_out,   14'b1000000_1000000);
      check("rst_act",   gpio_act,  1'b0);
      check("rst_vga",   vga_clk,   1'b0);
      check("rst_pix",   pix_en,    1'b0);
      $display("test reset done");

      // Short glitch then a full press of key0 in mode 0.
      npulse = 0;
      key_n[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin step(1); npulse += int'(key_pulse[0]); end
      key_n[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin step(1); npulse += int'(key_pulse[0]); end
      check("glitch_pulses", 64'(npulse), 64'd0);
      check("glitch_cnt", event_cnt, 8'h00);
      npulse = 0;
      key_n[0] = 1'b0;
      step(5);
      check("press_early", key_pulse[0], 1'b0);
      step(1);
      check("press_lat6", key_pulse[0], 1'b1);
      check("press_level", key_level[0], 1'b1);
      npulse = 1;
      step(1);
      npulse += int'(key_pulse[0]);
      check("press_cnt", event_cnt, 8'h01);
      step(1);
      npulse += int'(key_pulse[0]);
      check("press_hex", hex_out[6:0], 7'b1111001);
      step(2);
      key_n[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin step(1); npulse += int'(key_pulse[0]); end
      check("press_pulses", 64'(npulse), 64'd1);
      $display("test debounce done");

      // VGA divider pattern from reset.
      do_reset();
      vga_pat = 16'hCCCC;
      pix_pat = 16'h4444;
      npix = 0;
      for (int i = 0; i < 16; i++) begin
         check("vga_pat", vga_clk, vga_pat[i]);
         check("pix_pat", pix_en, pix_pat[i]);
         npix += int'(pix_en);
         step(1);
      end
      check("pix_total", 64'(npix), 64'd4);
      $display("test vga done");

      // Mode 2 tick, then hold on/off via key2.
      mode = 2'd2;
      do_reset();
      step(35);
      check("tick_cnt3", event_cnt, 8'h03);
      key_n[2] = 1'b0; step(8); key_n[2] = 1'b1;
      step(30);
      check("hold_frozen", event_cnt, 8'h04);
      key_n[2] = 1'b0; step(8); key_n[2] = 1'b1;
      step(14);
      check("hold_resumed", event_cnt, 8'h05);
      $display("test tick_hold done");

      // Mode 1 GPIO activity and set-over-clear.
      mode = 2'd1;
      do_reset();
      gpio[17] = 1'b1; step(1); gpio = '0;
      step(2);
      check("gpio_act_set", gpio_act, 1'b1);
      check("gpio_cnt1", event_cnt, 8'h01);
      step(7);
      key_n[3] = 1'b0;
      step(4);
      gpio[17] = 1'b1; step(1); gpio = '0;
      step(2);
      check("act_set_wins", gpio_act, 1'b1);
      check("gpio_cnt2", event_cnt, 8'h02);
      step(6);
      key_n[3] = 1'b1;
      step(8);
      key_n[3] = 1'b0; step(8); key_n[3] = 1'b1;
      step(2);
      check("act_cleared", gpio_act, 1'b0);
      $display("test gpio done");

      // Drive the counter to all-ones, then wrap.
      do_reset();
      for (int i = 0; i < 255; i++) begin
         gpio[0] = 1'b1; step(1); gpio = '0; step(1);
      end
      step(3);
      check("wrap_ff", event_cnt, 8'hFF);
      check("wrap_hex_ff", hex_out, 14'b0001110_0001110);
      gpio[0] = 1'b1; step(1); gpio = '0; step(3);
      check("wrap_00", event_cnt, 8'h00);
      $display("test wrap done");

      // Clear beats a simultaneous count press.
      mode = 2'd0;
      key_n[0] = 1'b0; step(8); key_n[0] = 1'b1; step(6);
      check("clr_pre", event_cnt, 8'h01);
      key_n[1:0] = 2'b00; step(8); key_n[1:0] = 2'b11; step(6);
      check("clr_wins", event_cnt, 8'h00);
      $display("test clear done");

      // Switch display in mode 3.
      sw = 8'hA5; mode = 2'd3;
      step(2);
      check("sw_hex", hex_out, 14'b0001000_0010010);
      check("sw_cnt", event_cnt, 8'h00);
      $display("test switch done");

      // Reset during a press restarts its debounce.
      mode = 2'd0;
      key_n[0] = 1'b0; step(3);
      rst = 1'b1; step(1); rst = 1'b0;
      step(8);
      key_n[0] = 1'b1;
      step(4);
      check("midrst_cnt", event_cnt, 8'h01);
      $display("test mid_reset done");

      // Randomized traffic checked by the model each cycle.
      for (int k = 0; k < NK; k++) dur[k] = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < NK; k++) begin
            if (dur[k] == 0) begin
               key_n[k] = 1'($urandom_range(0, 1));
               dur[k] = int'($urandom_range(1, 9));
            end else begin
               dur[k]--;
            end
         end
         gpio = ($urandom_range(0, 3) == 0) ? (GW'(1) << $urandom_range(0, GW-1)) : '0;
         if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
         sw  = CW'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);
      $display("test random done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
